// File: rtl/axi_mem_pkg.sv
// Shared encodings and constants for the AXI ROM read front end.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  // One ROM word is 16 bytes, so byte addresses shift right by 4.
  localparam int BEAT_SHIFT = 4;

  typedef enum logic {IDLE, BURST} state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_rom_rd_ctrl_if.sv
// AXI4 AR and R channel bundle between the interconnect master and the ROM front end.
interface axi_rom_rd_ctrl_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 128,
  parameter int ID_WD   = 4
);
  logic               arvalid;
  logic               arready;
  logic [ADDR_WD-1:0] araddr;
  logic [ID_WD-1:0]   arid;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               rvalid;
  logic               rready;
  logic [DATA_WD-1:0] rdata;
  logic [ID_WD-1:0]   rid;
  logic [1:0]         rresp;
  logic               rlast;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/axi_rom_rd_buf.sv
// Two-entry FIFO holding packed {rdata, rid, rresp, rlast} beats awaiting the R handshake.
module axi_rom_rd_buf #(
  parameter int WIDTH = 135
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_ent0;
  logic [WIDTH-1:0] r_ent1;
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        if (r_wptr) r_ent1 <= i_wdata;
        else        r_ent0 <= i_wdata;
        r_wptr <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_rptr ? r_ent1 : r_ent0;
  assign o_count = r_count;

endmodule

// File: rtl/axi_rom_rd_ctrl.sv
// AXI4 read front end for the 2048x128 ROM: walks burst addresses, issues reads
// under a two-beat credit, and returns R beats through a small buffer.
module axi_rom_rd_ctrl
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WD    = 32,
  parameter int DATA_WD    = 128,
  parameter int ID_WD      = 4,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                clk,
  input  logic                rst,
  axi_rom_rd_ctrl_if.slave    bus,
  output logic [ADDR_WD-1:0]  rom_addr,
  output logic                rom_rd_en,
  input  logic [DATA_WD-1:0]  rom_rdata
);

  localparam int ENT_WD = DATA_WD + ID_WD + 3;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_WD-1:0]      r_id;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic                  r_oor;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DEPTH_LOG2-1:0] r_wrap_mask;
  logic [DEPTH_LOG2-1:0] w_idx_nxt;
  logic [8:0]            r_issue_left;
  logic [8:0]            r_beats_left;
  logic                  r_inflight;
  logic [ADDR_WD-1:0]    r_rom_addr;
  logic                  w_ar_hs;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_credit_ok;
  logic                  w_arready;
  logic                  w_ar_oor;
  logic                  w_ar_bad_burst;
  logic                  w_ar_bad_wrap;
  logic [1:0]            w_buf_count;
  logic [DATA_WD-1:0]    w_push_data;
  logic [1:0]            w_push_resp;
  logic [ENT_WD-1:0]     w_buf_wdata;
  logic [ENT_WD-1:0]     w_buf_rdata;
  logic                  w_unused_ok;

  assign w_ar_hs        = bus.arvalid & w_arready;
  assign w_pop          = bus.rvalid & bus.rready;
  assign bus.arready    = w_arready;
  assign w_ar_oor       = |bus.araddr[ADDR_WD-1:DEPTH_LOG2+BEAT_SHIFT];
  assign w_ar_bad_burst = (bus.arburst == 2'd3);
  assign w_ar_bad_wrap  = (bus.arburst == BURST_WRAP) && !wrap_len_ok(bus.arlen);
  assign w_unused_ok    = ^{bus.arsize, bus.araddr[BEAT_SHIFT-1:0]};

  // A beat popped this cycle frees its slot in time for a new read to land behind it.
  assign w_credit_ok = ({1'b0, w_buf_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arready   = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        w_arready = 1'b1;
        if (bus.arvalid) w_state_nxt = BURST;
      end
      BURST: begin
        w_issue = (r_issue_left != 9'd0) && w_credit_ok;
        if (w_pop && bus.rlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_idx_nxt = r_idx + DEPTH_LOG2'(1);
    case (r_burst)
      BURST_FIXED: w_idx_nxt = r_idx;
      BURST_WRAP:  w_idx_nxt = (r_idx & ~r_wrap_mask) | ((r_idx + DEPTH_LOG2'(1)) & r_wrap_mask);
      default:     w_idx_nxt = r_idx + DEPTH_LOG2'(1);
    endcase
  end

  // Out-of-range bursts still consume credit and issue slots, they just never touch the ROM.
  assign rom_rd_en = w_issue & ~r_oor;
  assign rom_addr  = rom_rd_en ? ADDR_WD'(r_idx) : r_rom_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id         <= '0;
      r_burst      <= BURST_INCR;
      r_err        <= 1'b0;
      r_oor        <= 1'b0;
      r_idx        <= '0;
      r_wrap_mask  <= '0;
      r_issue_left <= '0;
      r_beats_left <= '0;
      r_inflight   <= 1'b0;
      r_rom_addr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_ar_hs) begin
        r_id         <= bus.arid;
        r_burst      <= (w_ar_bad_burst || w_ar_bad_wrap) ? BURST_INCR : bus.arburst;
        r_err        <= w_ar_oor | w_ar_bad_burst | w_ar_bad_wrap;
        r_oor        <= w_ar_oor;
        r_idx        <= bus.araddr[DEPTH_LOG2+BEAT_SHIFT-1:BEAT_SHIFT];
        r_wrap_mask  <= DEPTH_LOG2'(bus.arlen);
        r_issue_left <= {1'b0, bus.arlen} + 9'd1;
        r_beats_left <= {1'b0, bus.arlen} + 9'd1;
      end
      if (w_issue) begin
        r_idx        <= w_idx_nxt;
        r_issue_left <= r_issue_left - 9'd1;
      end
      if (r_inflight) r_beats_left <= r_beats_left - 9'd1;
      if (rom_rd_en)  r_rom_addr   <= rom_addr;
    end
  end

  assign w_push_data = r_oor ? '0 : rom_rdata;
  assign w_push_resp = r_err ? RESP_SLVERR : RESP_OKAY;
  assign w_buf_wdata = {w_push_data, r_id, w_push_resp, (r_beats_left == 9'd1)};

  axi_rom_rd_buf #(
    .WIDTH(ENT_WD)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_wdata (w_buf_wdata),
    .o_rdata (w_buf_rdata),
    .o_count (w_buf_count)
  );

  assign bus.rvalid = (w_buf_count != 2'd0);
  assign {bus.rdata, bus.rid, bus.rresp, bus.rlast} = w_buf_rdata;

endmodule

// File: tb/tb_axi_rom_rd_ctrl.sv
// Bench for axi_rom_rd_ctrl: ROM model, burst driver, and a burst-rule reference model.
module tb_axi_rom_rd_ctrl;

  localparam int ADDR_WD    = 32;
  localparam int DATA_WD    = 128;
  localparam int ID_WD      = 4;
  localparam int DEPTH_LOG2 = 11;
  localparam int WORDS      = 2048;

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_WD-1:0] rom_addr;
  logic               rom_rd_en;
  logic [DATA_WD-1:0] rom_rdata;
  logic [DATA_WD-1:0] mem [WORDS];

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int issued  = 0;
  int popped  = 0;
  int stall_err;
  int max_out;

  logic [DATA_WD-1:0] obs_data[$];
  logic [1:0]         obs_resp[$];
  logic               obs_last[$];
  logic [ID_WD-1:0]   obs_id[$];
  int                 obs_addr[$];
  int                 obs_icyc[$];
  int                 obs_pcyc[$];

  logic [DATA_WD-1:0] exp_data[$];
  logic [1:0]         exp_resp[$];
  logic               exp_last[$];
  int                 exp_word[$];
  logic [ID_WD-1:0]   exp_id;
  bit                 exp_oor;

  axi_rom_rd_ctrl_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .ID_WD(ID_WD)) bus ();

  axi_rom_rd_ctrl #(
    .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .ID_WD(ID_WD), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rom_addr  (rom_addr),
    .rom_rd_en (rom_rd_en),
    .rom_rdata (rom_rdata)
  );

  always #5 clk = ~clk;

  // ROM with one cycle of registered read latency, plus issue/pop monitors.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rom_rd_en) begin
      rom_rdata <= mem[rom_addr[DEPTH_LOG2-1:0]];
      issued    <= issued + 1;
      obs_addr.push_back(int'(rom_addr));
      obs_icyc.push_back(cyc_cnt);
    end
    if (bus.rvalid && bus.rready) popped <= popped + 1;
  end

  // Reference model: expected word order, data and response from the burst rules.
  task automatic build_exp(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [ID_WD-1:0] id);
    int  n;
    int  start;
    bit  wrap_ok;
    bit  err;
    n       = len + 1;
    start   = int'(addr >> 4) % WORDS;
    exp_oor = (addr >= 32'(WORDS * 16));
    wrap_ok = (burst == 2'd2) && (n == 2 || n == 4 || n == 8 || n == 16);
    err     = exp_oor || (burst == 2'd3) || ((burst == 2'd2) && !wrap_ok);
    exp_id  = id;
    exp_data.delete(); exp_resp.delete(); exp_last.delete(); exp_word.delete();
    for (int k = 0; k < n; k++) begin
      int w;
      if (burst == 2'd0)  w = start;
      else if (wrap_ok)   w = (start / n) * n + ((start % n) + k) % n;
      else                w = (start + k) % WORDS;
      exp_word.push_back(w);
      exp_data.push_back(exp_oor ? '0 : mem[w]);
      exp_resp.push_back(err ? 2'd2 : 2'd0);
      exp_last.push_back(k == n - 1);
    end
  endtask

  // Drives one AR, then collects R beats under the chosen rready pattern.
  task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [ID_WD-1:0] id, input int mode, output bit tmo);
    int n;
    int base;
    bit done;
    bit stalled;
    logic [DATA_WD+ID_WD+3:0] prev;
    logic [DATA_WD+ID_WD+3:0] cur;
    obs_data.delete(); obs_resp.delete(); obs_last.delete(); obs_id.delete();
    obs_addr.delete(); obs_icyc.delete(); obs_pcyc.delete();
    stall_err = 0; max_out = 0; done = 0; stalled = 0; n = 0; prev = '0;
    @(negedge clk);
    base = issued - popped;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
    bus.arid = id; bus.arsize = 3'd4;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      case (mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = (n % 4 == 0) || (n % 4 == 3);
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      cur = {bus.rvalid, bus.rdata, bus.rid, bus.rresp, bus.rlast};
      if (stalled && cur !== prev) stall_err++;
      stalled = bus.rvalid && !bus.rready;
      prev = cur;
      if (issued - popped - base > max_out) max_out = issued - popped - base;
      if (bus.rvalid && bus.rready) begin
        obs_data.push_back(bus.rdata); obs_resp.push_back(bus.rresp);
        obs_last.push_back(bus.rlast); obs_id.push_back(bus.rid);
        obs_pcyc.push_back(cyc_cnt);
        if (bus.rlast || obs_data.size() > int'(len) + 1) done = 1;
      end
      @(negedge clk);
      n++;
    end
    bus.rready = 1'b1;
    tmo = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.arsize = 3'd4; bus.arburst = 2'd1; bus.rready = 1'b0;
    for (int i = 0; i < WORDS; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(negedge clk);
    total++; if (bus.arready !== 1'b1) begin bad++; $display("[TB] FAIL reset_arready got=%b exp=1", bus.arready); end
    total++; if (bus.rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
    total++; if ({bus.rdata, bus.rid, bus.rresp, bus.rlast} !== '0) begin bad++;
      $display("[TB] FAIL reset_rfields got=%h/%h/%h/%b exp=0", bus.rdata, bus.rid, bus.rresp, bus.rlast); end
    total++; if (rom_rd_en !== 1'b0 || rom_addr !== '0) begin bad++;
      $display("[TB] FAIL reset_rom got=%b/%h exp=0/0", rom_rd_en, rom_addr); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.arready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_arready got=%b exp=1", bus.arready); end
  endtask

  task automatic test_single();
    bus.rready = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = 32'h20; bus.arlen = 8'd0; bus.arburst = 2'd1; bus.arid = 4'd5;
    total++; if (bus.arready !== 1'b1) begin bad++; $display("[TB] FAIL single_c0_arready got=%b exp=1", bus.arready); end
    @(negedge clk);
    bus.arvalid = 1'b0;
    total++; if (rom_rd_en !== 1'b1 || rom_addr !== 32'd2) begin bad++;
      $display("[TB] FAIL single_c1_rom got=%b/%0d exp=1/2", rom_rd_en, rom_addr); end
    @(negedge clk);
    total++; if (bus.rvalid !== 1'b0) begin bad++; $display("[TB] FAIL single_c2_rvalid got=%b exp=0", bus.rvalid); end
    @(negedge clk);
    total++; if ({bus.rvalid, bus.rdata, bus.rid, bus.rresp, bus.rlast} !== {1'b1, mem[2], 4'd5, 2'd0, 1'b1}) begin bad++;
      $display("[TB] FAIL single_c3_beat got=%b/%h/%0d/%0d/%b exp=1/%h/5/0/1", bus.rvalid, bus.rdata, bus.rid, bus.rresp, bus.rlast, mem[2]); end
    @(negedge clk);
    total++; if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin bad++;
      $display("[TB] FAIL single_c4_idle got=%b/%b exp=1/0", bus.arready, bus.rvalid); end
  endtask

  task automatic test_incr();
    bit tmo;
    logic [ID_WD-1:0] id;
    id = ID_WD'($urandom);
    build_exp(32'h100, 7, 2'd1, id);
    do_burst(32'h100, 8'd7, 2'd1, id, 0, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("[TB] FAIL incr_timeout got=%b exp=0", tmo); end
    total++; if (obs_data.size() !== 8 || obs_addr.size() !== 8) begin bad++;
      $display("[TB] FAIL incr_count got=%0d/%0d exp=8/8", obs_data.size(), obs_addr.size()); end
    for (int i = 0; i < obs_data.size() && i < 8; i++) begin
      total++;
      if ({obs_data[i], obs_resp[i], obs_last[i], obs_id[i]} !== {exp_data[i], exp_resp[i], exp_last[i], exp_id}) begin bad++;
        $display("[TB] FAIL incr_beat%0d got=%h/%0d/%b/%0d exp=%h/%0d/%b/%0d", i, obs_data[i], obs_resp[i], obs_last[i], obs_id[i], exp_data[i], exp_resp[i], exp_last[i], exp_id); end
      total++;
      if (obs_pcyc[i] !== obs_pcyc[0] + i) begin bad++;
        $display("[TB] FAIL incr_pop_cycle%0d got=%0d exp=%0d", i, obs_pcyc[i], obs_pcyc[0] + i); end
    end
    for (int i = 0; i < obs_addr.size() && i < 8; i++) begin
      total++;
      if (obs_addr[i] !== 16 + i || obs_icyc[i] !== obs_icyc[0] + i) begin bad++;
        $display("[TB] FAIL incr_addr%0d got=%0d@%0d exp=%0d@%0d", i, obs_addr[i], obs_icyc[i], 16 + i, obs_icyc[0] + i); end
    end
  endtask

  task automatic test_wrap();
    bit tmo;
    logic [31:0] addrs [2];
    addrs[0] = 32'h1C0;
    addrs[1] = 32'h1E0;
    for (int b = 0; b < 2; b++) begin
      build_exp(addrs[b], 3, 2'd2, 4'd9);
      do_burst(addrs[b], 8'd3, 2'd2, 4'd9, 0, tmo);
      total++; if (tmo !== 1'b0 || obs_data.size() !== 4 || obs_addr.size() !== 4) begin bad++;
        $display("[TB] FAIL wrap%0d_count got=%b/%0d/%0d exp=0/4/4", b, tmo, obs_data.size(), obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
        total++;
        if (obs_addr[i] !== exp_word[i]) begin bad++;
          $display("[TB] FAIL wrap%0d_addr%0d got=%0d exp=%0d", b, i, obs_addr[i], exp_word[i]); end
      end
      for (int i = 0; i < obs_data.size() && i < 4; i++) begin
        total++;
        if ({obs_data[i], obs_resp[i], obs_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin bad++;
          $display("[TB] FAIL wrap%0d_beat%0d got=%h/%0d/%b exp=%h/%0d/%b", b, i, obs_data[i], obs_resp[i], obs_last[i], exp_data[i], exp_resp[i], exp_last[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit tmo;
    logic [31:0] addr;
    addr = 32'($urandom_range(0, WORDS - 1)) << 4;
    build_exp(addr, 15, 2'd1, 4'd3);
    do_burst(addr, 8'd15, 2'd1, 4'd3, 1, tmo);
    total++; if (tmo !== 1'b0 || obs_data.size() !== 16) begin bad++;
      $display("[TB] FAIL bp_count got=%b/%0d exp=0/16", tmo, obs_data.size()); end
    total++; if (stall_err !== 0) begin bad++; $display("[TB] FAIL bp_stable got=%0d changes exp=0", stall_err); end
    total++; if (max_out > 2) begin bad++; $display("[TB] FAIL bp_outstanding got=%0d exp<=2", max_out); end
    for (int i = 0; i < obs_data.size() && i < 16; i++) begin
      total++;
      if ({obs_data[i], obs_resp[i], obs_last[i], obs_id[i]} !== {exp_data[i], exp_resp[i], exp_last[i], exp_id}) begin bad++;
        $display("[TB] FAIL bp_beat%0d got=%h/%0d/%b/%0d exp=%h/%0d/%b/%0d", i, obs_data[i], obs_resp[i], obs_last[i], obs_id[i], exp_data[i], exp_resp[i], exp_last[i], exp_id); end
    end
  endtask

  task automatic test_error();
    bit tmo;
    build_exp(32'h8000, 1, 2'd1, 4'd1);
    do_burst(32'h8000, 8'd1, 2'd1, 4'd1, 0, tmo);
    total++; if (tmo !== 1'b0 || obs_data.size() !== 2 || obs_addr.size() !== 0) begin bad++;
      $display("[TB] FAIL oor_count got=%b/%0d beats/%0d reads exp=0/2/0", tmo, obs_data.size(), obs_addr.size()); end
    for (int i = 0; i < obs_data.size() && i < 2; i++) begin
      total++;
      if ({obs_data[i], obs_resp[i], obs_last[i]} !== {128'd0, 2'd2, exp_last[i]}) begin bad++;
        $display("[TB] FAIL oor_beat%0d got=%h/%0d/%b exp=0/2/%b", i, obs_data[i], obs_resp[i], obs_last[i], exp_last[i]); end
    end
    build_exp(32'h40, 2, 2'd2, 4'd2);
    do_burst(32'h40, 8'd2, 2'd2, 4'd2, 0, tmo);
    total++; if (tmo !== 1'b0 || obs_data.size() !== 3 || obs_addr.size() !== 3) begin bad++;
      $display("[TB] FAIL badwrap_count got=%b/%0d/%0d exp=0/3/3", tmo, obs_data.size(), obs_addr.size()); end
    for (int i = 0; i < obs_data.size() && i < 3; i++) begin
      total++;
      if ({obs_data[i], obs_resp[i], obs_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]} || obs_addr[i] !== 4 + i) begin bad++;
        $display("[TB] FAIL badwrap_beat%0d got=%h/%0d/%b@%0d exp=%h/%0d/%b@%0d", i, obs_data[i], obs_resp[i], obs_last[i], obs_addr[i], exp_data[i], exp_resp[i], exp_last[i], 4 + i); end
    end
  endtask

  // First three rounds pin boundary cases (top-of-ROM INCR, FIXED, arburst=3), the rest are random.
  task automatic test_random();
    bit tmo;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [ID_WD-1:0] id;
    int mode;
    for (int t = 0; t < 23; t++) begin
      id = ID_WD'($urandom);
      mode = $urandom_range(0, 2);
      if (t == 0)      begin addr = 32'h7FE0; len = 8'd3; burst = 2'd1; end
      else if (t == 1) begin addr = 32'h50;   len = 8'd3; burst = 2'd0; end
      else if (t == 2) begin addr = 32'h3A0;  len = 8'd4; burst = 2'd3; end
      else begin
        burst = 2'($urandom_range(0, 3));
        len = ($urandom_range(0, 2) == 0) ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 20));
        addr = ($urandom_range(0, 7) == 0) ? 32'h8000 + 32'($urandom_range(0, 4095))
                                           : (32'($urandom_range(0, WORDS - 1)) << 4) | 32'($urandom_range(0, 15));
      end
      build_exp(addr, int'(len), burst, id);
      do_burst(addr, len, burst, id, mode, tmo);
      total++; if (tmo !== 1'b0 || obs_data.size() !== exp_data.size()) begin bad++;
        $display("[TB] FAIL rand%0d_count addr=%h len=%0d burst=%0d got=%b/%0d exp=0/%0d", t, addr, len, burst, tmo, obs_data.size(), exp_data.size()); end
      total++; if (obs_addr.size() !== (exp_oor ? 0 : exp_word.size())) begin bad++;
        $display("[TB] FAIL rand%0d_reads got=%0d exp=%0d", t, obs_addr.size(), exp_oor ? 0 : exp_word.size()); end
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
        total++;
        if ({obs_data[i], obs_resp[i], obs_last[i], obs_id[i]} !== {exp_data[i], exp_resp[i], exp_last[i], exp_id}) begin bad++;
          $display("[TB] FAIL rand%0d_beat%0d got=%h/%0d/%b/%0d exp=%h/%0d/%b/%0d", t, i, obs_data[i], obs_resp[i], obs_last[i], obs_id[i], exp_data[i], exp_resp[i], exp_last[i], exp_id); end
      end
      for (int i = 0; i < obs_addr.size() && i < exp_word.size(); i++) begin
        total++;
        if (obs_addr[i] !== exp_word[i]) begin bad++;
          $display("[TB] FAIL rand%0d_addr%0d got=%0d exp=%0d", t, i, obs_addr[i], exp_word[i]); end
      end
      total++; if (stall_err !== 0 || max_out > 2) begin bad++;
        $display("[TB] FAIL rand%0d_flow got=%0d changes/%0d outstanding exp=0/<=2", t, stall_err, max_out); end
    end
  endtask

  task automatic test_reset_mid();
    bit tmo;
    int pops;
    int n;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = 32'h200; bus.arlen = 8'd7; bus.arburst = 2'd1; bus.arid = 4'd7;
    @(negedge clk);
    bus.arvalid = 1'b0;
    pops = 0; n = 0;
    while (pops < 3 && n < 100) begin
      if (bus.rvalid && bus.rready) pops++;
      @(negedge clk);
      n++;
    end
    total++; if (pops !== 3) begin bad++; $display("[TB] FAIL midrst_pops got=%0d exp=3", pops); end
    rst = 1'b1;
    #1;
    total++; if (bus.rvalid !== 1'b0 || rom_rd_en !== 1'b0) begin bad++;
      $display("[TB] FAIL midrst_clear got=%b/%b exp=0/0", bus.rvalid, rom_rd_en); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin bad++;
      $display("[TB] FAIL midrst_idle got=%b/%b exp=1/0", bus.arready, bus.rvalid); end
    build_exp(32'h0, 0, 2'd1, 4'd11);
    do_burst(32'h0, 8'd0, 2'd1, 4'd11, 0, tmo);
    total++; if (tmo !== 1'b0 || obs_data.size() !== 1 || obs_addr.size() !== 1) begin bad++;
      $display("[TB] FAIL midrst_next_count got=%b/%0d/%0d exp=0/1/1", tmo, obs_data.size(), obs_addr.size()); end
    if (obs_data.size() > 0) begin
      total++;
      if ({obs_data[0], obs_resp[0], obs_last[0], obs_id[0]} !== {mem[0], 2'd0, 1'b1, 4'd11}) begin bad++;
        $display("[TB] FAIL midrst_next_beat got=%h/%0d/%b/%0d exp=%h/0/1/11", obs_data[0], obs_resp[0], obs_last[0], obs_id[0], mem[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_wrap();
    test_backpressure();
    test_error();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
